// File: rtl/icache_assoc_if.sv
// rtl/icache_assoc_if.sv - fetch-side and memory-side signal bundle for icache_assoc
// master drives fetch requests and memory responses; slave is the cache itself.
interface icache_assoc_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        iflush;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;

  modport master (
    output imemREN, imemaddr, iflush, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  modport slave (
    input  imemREN, imemaddr, iflush, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );
endinterface

// File: rtl/icache_assoc.sv
// rtl/icache_assoc.sv - 1/2-way set-associative instruction cache with LRU and block fill
// Optional hit/miss counters enabled by ICACHE_STATS_EN.
module icache_assoc #(
  parameter int WAYS  = 2,
  parameter int SETS  = 8,
  parameter int WORDS = 2
) (
  input  logic CLK,
  input  logic RST,
  icache_assoc_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int WB  = $clog2(WORDS);
  localparam int IB  = $clog2(SETS);
  localparam int TW  = 30 - WB - IB;
  localparam int WIW = (WB > 0) ? WB : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t              state;
  logic [1:0][SETS-1:0] valid;
  logic [SETS-1:0]     lru;
  logic [TW-1:0]       tag_mem  [2][SETS];
  logic [31:0]         data_mem [2][SETS][WORDS];
  logic [31:0]         fill_buf [WORDS];
  logic [31:0]         fill_base;
  logic [WIW-1:0]      cnt;

  logic [IB-1:0]  req_idx, fill_idx;
  logic [TW-1:0]  req_tag, fill_tag;
  logic [WIW-1:0] req_word;
  logic [1:0]     match;
  logic           any_hit, hit_way, victim;
  logic           capture, done;
  logic           unused_bits;

  assign req_idx  = bus.imemaddr[2+WB +: IB];
  assign req_tag  = bus.imemaddr[31 -: TW];
  assign req_word = (WB > 0) ? bus.imemaddr[2 +: WIW] : '0;
  assign fill_idx = fill_base[2+WB +: IB];
  assign fill_tag = fill_base[31 -: TW];
  assign unused_bits = ^bus.imemaddr[1:0];

  assign match[0] = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
  assign match[1] = (WAYS == 2) && valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
  assign any_hit  = |match;
  assign hit_way  = match[1];

  assign bus.ihit     = !RST && (state == IDLE) && bus.imemREN && !bus.iflush && any_hit;
  assign bus.imemload = bus.ihit ? data_mem[hit_way][req_idx][req_word] : '0;
  assign bus.iREN     = !RST && (state == FILL);
  assign bus.iaddr    = bus.iREN ? fill_base + (32'(cnt) << 2) : '0;

  // Fill empty ways first, otherwise replace the least-recently-used one.
  always_comb begin
    victim = 1'b0;
    if (WAYS == 2) begin
      if (!valid[0][fill_idx])      victim = 1'b0;
      else if (!valid[1][fill_idx]) victim = 1'b1;
      else                          victim = lru[fill_idx];
    end
  end

  assign capture = (state == FILL) && !bus.iflush && !bus.iwait;
  assign done    = capture && (cnt == WIW'(WORDS - 1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      valid     <= '0;
      lru       <= '0;
      cnt       <= '0;
      fill_base <= '0;
`ifdef ICACHE_STATS_EN
      hit_count  <= '0;
      miss_count <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.iflush) begin
            valid <= '0;
            lru   <= '0;
          end else if (bus.imemREN) begin
            if (any_hit) begin
              if (WAYS == 2) lru[req_idx] <= ~hit_way;
`ifdef ICACHE_STATS_EN
              if (hit_count != '1) hit_count <= hit_count + 32'd1;
`endif
            end else begin
              fill_base <= bus.imemaddr & ~32'(4 * WORDS - 1);
              cnt       <= '0;
              state     <= FILL;
`ifdef ICACHE_STATS_EN
              if (miss_count != '1) miss_count <= miss_count + 32'd1;
`endif
            end
          end
        end
        FILL: begin
          if (bus.iflush) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (!bus.iwait) begin
            if (done) begin
              valid[victim][fill_idx] <= 1'b1;
              if (WAYS == 2) lru[fill_idx] <= ~victim;
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + WIW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The final word goes straight from iload into the array on the completing edge.
  always_ff @(posedge CLK) begin
    if (capture) fill_buf[cnt] <= bus.iload;
    if (done) begin
      tag_mem[victim][fill_idx] <= fill_tag;
      for (int w = 0; w < WORDS; w++) begin
        data_mem[victim][fill_idx][w] <= (w == WORDS - 1) ? bus.iload : fill_buf[w];
      end
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb/tb_icache_assoc.sv - directed and random fetch sequences against an LRU-list cache model
// Define ICACHE_STATS_EN to also check the hit/miss counters.
module tb_icache_assoc;
  localparam int WAYS  = 2;
  localparam int SETS  = 8;
  localparam int WORDS = 2;

  logic CLK;
  logic RST;
  icache_assoc_if bus();
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_assoc #(.WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int model_misses = 0;
  int obs_hits = 0;
  int obs_base = 0;
  int unsigned lines [SETS][$];

  always @(posedge CLK) if (!RST && bus.ihit) obs_hits++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h11;
    if (a == 32'h4) return 32'h22;
    return (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction

  function automatic int unsigned blk_of(input logic [31:0] a);
    return a / (4 * WORDS);
  endfunction

  function automatic int find_line(input logic [31:0] a);
    int unsigned b = blk_of(a);
    int s = b % SETS;
    foreach (lines[s][i]) if (lines[s][i] == b) return i;
    return -1;
  endfunction

  function automatic void model_touch(input logic [31:0] a);
    int unsigned b = blk_of(a);
    int s = b % SETS;
    int k = find_line(a);
    if (k >= 0) lines[s].delete(k);
    lines[s].push_front(b);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    int unsigned b = blk_of(a);
    int s = b % SETS;
    if (lines[s].size() == WAYS) void'(lines[s].pop_back());
    lines[s].push_front(b);
  endfunction

  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) lines[s].delete();
  endfunction

  // exp_hit: 0/1 directed expectation, 2 = take it from the model.
  task automatic fetch(input logic [31:0] addr, input int exp_hit, input bit paced);
    logic [31:0] base;
    int got, guard;
    bit w, eh;
    eh = (exp_hit == 2) ? (find_line(addr) >= 0) : (exp_hit != 0);
    bus.imemREN = 1'b1; bus.imemaddr = addr; bus.iflush = 1'b0;
    bus.iwait = 1'($urandom_range(0, 1));
    #1;
    check("idle_hit", 32'(bus.ihit), 32'(eh));
    check("idle_iren", 32'(bus.iREN), 32'd0);
    check("idle_iaddr", bus.iaddr, 32'd0);
    if (eh) begin
      check("hit_data", bus.imemload, mem_word(addr));
      model_touch(addr);
      @(posedge CLK); @(negedge CLK);
      return;
    end
    check("miss_load", bus.imemload, 32'd0);
    model_misses++;
    @(posedge CLK); @(negedge CLK);
    base = addr & ~32'(4 * WORDS - 1);
    got = 0; guard = 0; w = 1'b0;
    while (got < WORDS && guard < 64) begin
      w = paced ? !w : 1'($urandom_range(0, 1));
      bus.iwait = w;
      bus.iload = w ? $urandom : mem_word(base + 32'(4 * got));
      if (!paced) begin
        bus.imemaddr = $urandom;
        bus.imemREN  = 1'($urandom_range(0, 1));
      end
      #1;
      check("fill_iren", 32'(bus.iREN), 32'd1);
      check("fill_iaddr", bus.iaddr, base + 32'(4 * got));
      check("fill_hit", 32'(bus.ihit), 32'd0);
      @(posedge CLK);
      if (!w) got++;
      @(negedge CLK);
      guard++;
    end
    check("fill_complete", 32'(got), 32'(WORDS));
    bus.imemREN = 1'b1; bus.imemaddr = addr; bus.iwait = 1'b1;
    model_fill(addr);
    #1;
    check("ret_hit", 32'(bus.ihit), 32'd1);
    check("ret_data", bus.imemload, mem_word(addr));
    check("ret_iren", 32'(bus.iREN), 32'd0);
    @(posedge CLK); @(negedge CLK);
  endtask

  task automatic flush_idle();
    bus.imemREN = 1'($urandom_range(0, 1));
    bus.imemaddr = 32'($urandom_range(0, 63)) * 4;
    bus.iflush = 1'b1;
    #1;
    check("flush_hit", 32'(bus.ihit), 32'd0);
    @(posedge CLK); @(negedge CLK);
    bus.iflush = 1'b0;
    model_clear();
  endtask

  task automatic reset_outputs_zero(input string tag);
    check({tag, "_ihit"}, 32'(bus.ihit), 32'd0);
    check({tag, "_iren"}, 32'(bus.iREN), 32'd0);
    check({tag, "_iaddr"}, bus.iaddr, 32'd0);
    check({tag, "_load"}, bus.imemload, 32'd0);
  endtask

  initial begin
    RST = 1'b1;
    bus.imemREN = 1'b1; bus.imemaddr = 32'h0; bus.iflush = 1'b0;
    bus.iwait = 1'b0; bus.iload = 32'h0;
    model_clear();
    @(negedge CLK);
    reset_outputs_zero("reset");
    RST = 1'b0;

    // Cold fetch with one wait cycle per word, then same-block hit.
    fetch(32'h00, 0, 1'b1);
`ifdef ICACHE_STATS_EN
    check("stats_miss1", miss_count, 32'd1);
    check("stats_hit1", hit_count, 32'(obs_hits - obs_base));
`endif
    fetch(32'h04, 1, 1'b0);

    // LRU eviction within set 0.
    flush_idle();
    fetch(32'h00, 0, 1'b0);
    fetch(32'h40, 0, 1'b0);
    fetch(32'h00, 1, 1'b0);
    fetch(32'h80, 0, 1'b0);
    fetch(32'h00, 1, 1'b0);
    fetch(32'h40, 0, 1'b0);

    // No request: memory side must stay quiet.
    bus.imemREN = 1'b0; bus.imemaddr = 32'h100;
    for (int i = 0; i < 6; i++) begin
      bus.iwait = 1'(i);
      #1;
      check("quiet_iren", 32'(bus.iREN), 32'd0);
      check("quiet_hit", 32'(bus.ihit), 32'd0);
      @(posedge CLK); @(negedge CLK);
    end

    // Flush in IDLE suppresses a would-be hit.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h00; bus.iflush = 1'b1;
    #1;
    check("flush_cached_hit", 32'(bus.ihit), 32'd0);
    @(posedge CLK); @(negedge CLK);
    bus.iflush = 1'b0;
    model_clear();

    // Abort a fill on the first word capture.
    bus.imemREN = 1'b1; bus.imemaddr = 32'h00;
    #1;
    check("abort_miss", 32'(bus.ihit), 32'd0);
    @(posedge CLK); @(negedge CLK);
    bus.iwait = 1'b0; bus.iflush = 1'b1; bus.iload = mem_word(32'h0);
    #1;
    check("abort_iren_before", 32'(bus.iREN), 32'd1);
    @(posedge CLK); @(negedge CLK);
    bus.iflush = 1'b0; bus.imemREN = 1'b0;
    #1;
    check("abort_iren_after", 32'(bus.iREN), 32'd0);
    check("abort_iaddr_after", bus.iaddr, 32'd0);
    @(posedge CLK); @(negedge CLK);
    model_misses++;
    fetch(32'h00, 0, 1'b0);

    // Reset in the middle of a fill.
    fetch(32'h40, 2, 1'b0);
    bus.imemREN = 1'b1; bus.imemaddr = 32'h80;
    #1;
    check("rst_pre_miss", 32'(bus.ihit), 32'd0);
    @(posedge CLK); @(negedge CLK);
    bus.iwait = 1'b0; bus.iload = mem_word(32'h80);
    @(posedge CLK); @(negedge CLK);
    bus.imemaddr = 32'h40;
    #2 RST = 1'b1;
    #1 reset_outputs_zero("rst_mid");
    @(posedge CLK); #1;
    reset_outputs_zero("rst_edge");
    @(negedge CLK);
    RST = 1'b0;
    model_clear();
    model_misses = 0;
    obs_base = obs_hits;
    fetch(32'h40, 0, 1'b0);

    // Random traffic over 32 blocks mapping into 8 sets.
    for (int n = 0; n < 200; n++) begin
      int r = $urandom_range(0, 19);
      if (r == 0) flush_idle();
      else fetch(32'($urandom_range(0, 63)) * 4, 2, 1'($urandom_range(0, 1)));
    end

`ifdef ICACHE_STATS_EN
    check("stats_miss_final", miss_count, 32'(model_misses));
    check("stats_hit_final", hit_count, 32'(obs_hits - obs_base));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
